// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared limits and saturation helpers for signed arithmetic stages
//
// Purpose:
//   Common definitions for the signed arithmetic leaf stages.
//   - WIDTH_MIN / WIDTH_MAX: legal operand width range.
//   - sat_max(w): largest w-bit two's-complement value.
//   - sat_min(w): smallest w-bit two's-complement value.
//   - Both helpers return the value sign-extended to WIDTH_MAX bits.
//     Callers size-cast the result down to their own width.
// Ports: none (package).

package arith_pkg;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 32;

  // 2^(w-1) - 1, built from unsigned arithmetic so that w = 32 does not
  // overflow a signed intermediate.
  function automatic logic signed [WIDTH_MAX-1:0] sat_max(input int unsigned w);
    logic [WIDTH_MAX-1:0] msb_only;
    msb_only = {{(WIDTH_MAX-1){1'b0}}, 1'b1} << (w - 1);
    return signed'(msb_only - {{(WIDTH_MAX-1){1'b0}}, 1'b1});
  endfunction

  // -2^(w-1): the bitwise complement of sat_max(w).
  function automatic logic signed [WIDTH_MAX-1:0] sat_min(input int unsigned w);
    logic [WIDTH_MAX-1:0] msb_only;
    msb_only = {{(WIDTH_MAX-1){1'b0}}, 1'b1} << (w - 1);
    return signed'(~(msb_only - {{(WIDTH_MAX-1){1'b0}}, 1'b1}));
  endfunction

endpackage

// File: rtl/signed_add_core.sv
// rtl/signed_add_core.sv - combinational signed add/subtract with saturation
//
// Purpose:
//   Unregistered two's-complement adder/subtractor.
//   It produces a full-precision WIDTH+1 bit result and a WIDTH-bit
//   saturated copy, and it can be reused on its own elsewhere.
// Ports:
//   a       in   WIDTH    signed operand A
//   b       in   WIDTH    signed operand B
//   sub     in   1        0: a+b, 1: a-b
//   sum     out  WIDTH+1  signed full-precision result (never wraps)
//   sum_sat out  WIDTH    sum clamped to the WIDTH signed range
//   ovf     out  1        sum lies outside the WIDTH signed range

module signed_add_core
  import arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH:0]   sum,
  output logic [WIDTH-1:0] sum_sat,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] SAT_HI = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SAT_LO = WIDTH'(sat_min(WIDTH));

  logic [WIDTH:0] a_ext;
  logic [WIDTH:0] b_ext;

  // One guard bit is enough for both a+b and a-b of WIDTH-bit operands.
  // Modular arithmetic on the extended bits therefore gives the exact result.
  assign a_ext = {a[WIDTH-1], a};
  assign b_ext = {b[WIDTH-1], b};

  always_comb begin
    sum = sub ? (a_ext - b_ext) : (a_ext + b_ext);
    // The true sign is sum[WIDTH]. If it differs from sum[WIDTH-1], the
    // value cannot be represented in WIDTH bits.
    ovf = sum[WIDTH] ^ sum[WIDTH-1];
    if (!ovf) begin
      sum_sat = sum[WIDTH-1:0];
    end else if (sum[WIDTH]) begin
      sum_sat = SAT_LO;
    end else begin
      sum_sat = SAT_HI;
    end
  end

endmodule

// File: rtl/signed_adder.sv
// rtl/signed_adder.sv - registered valid-qualified signed adder/subtractor
//
// Purpose:
//   Single-cycle pipeline stage around signed_add_core.
//   Operands sampled with in_valid appear on the outputs one cycle later.
//   Result registers hold their value while in_valid is low.
//   All outputs come directly from flops.
// Ports:
//   clk       in   1        rising-edge clock
//   rst_n     in   1        asynchronous active-low reset
//   in_valid  in   1        operands valid this cycle
//   a         in   WIDTH    signed operand A
//   b         in   WIDTH    signed operand B
//   sub       in   1        0: a+b, 1: a-b
//   out_valid out  1        result registers hold a new result
//   sum       out  WIDTH+1  signed full-precision result
//   sum_sat   out  WIDTH    saturated result
//   ovf       out  1        sum outside the WIDTH signed range

module signed_adder
  import arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  output logic [WIDTH:0]   sum,
  output logic [WIDTH-1:0] sum_sat,
  output logic             ovf
);

  logic [WIDTH:0]   core_sum;
  logic [WIDTH-1:0] core_sum_sat;
  logic             core_ovf;

  signed_add_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a       (a),
    .b       (b),
    .sub     (sub),
    .sum     (core_sum),
    .sum_sat (core_sum_sat),
    .ovf     (core_ovf)
  );

  // out_valid follows in_valid every cycle.
  // The result registers load only on valid operands, so they keep the
  // last result between transactions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      sum_sat   <= '0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum     <= core_sum;
        sum_sat <= core_sum_sat;
        ovf     <= core_ovf;
      end
    end
  end

endmodule

// File: tb/tb_signed_adder.sv
// tb/tb_signed_adder.sv - self-checking bench for signed_adder at WIDTH 4 and 16

module tb_signed_adder;

  typedef struct {
    longint sum;
    longint sat;
    bit     ovf;
  } res_t;

  typedef struct {
    res_t r4;
    res_t r16;
  } sb_t;

  typedef struct {
    longint a;
    longint b;
    bit     sub;
    res_t   exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [3:0]  a4, b4;
  logic        sub4;
  logic [15:0] a16, b16;
  logic        sub16;
  logic        out_valid4, out_valid16;
  logic [4:0]  sum4;
  logic [3:0]  sum_sat4;
  logic        ovf4;
  logic [16:0] sum16;
  logic [15:0] sum_sat16;
  logic        ovf16;

  int n_checks = 0;
  int n_errors = 0;

  sb_t  sb[$];
  sb_t  held;
  vec_t tab[8];

  always #5 clk = ~clk;

  signed_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a(a4), .b(b4), .sub(sub4),
    .out_valid(out_valid4), .sum(sum4), .sum_sat(sum_sat4), .ovf(ovf4)
  );

  signed_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a(a16), .b(b16), .sub(sub16),
    .out_valid(out_valid16), .sum(sum16), .sum_sat(sum_sat16), .ovf(ovf16)
  );

  function automatic res_t model(input int w, input longint x, input longint y, input bit s);
    res_t   r;
    longint mx, mn;
    mx = (64'sd1 <<< (w - 1)) - 1;
    mn = -(mx + 1);
    r.sum = s ? (x - y) : (x + y);
    r.ovf = (r.sum > mx) || (r.sum < mn);
    r.sat = (r.sum > mx) ? mx : ((r.sum < mn) ? mn : r.sum);
    return r;
  endfunction

  function automatic vec_t mk(input longint x, input longint y, input bit s,
                              input longint es, input longint esat, input bit eo);
    vec_t v;
    v.a = x; v.b = y; v.sub = s;
    v.exp.sum = es; v.exp.sat = esat; v.exp.ovf = eo;
    return v;
  endfunction

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input bit v_exp, input sb_t e);
    chk("out_valid4", {63'd0, out_valid4}, {63'd0, v_exp});
    chk("out_valid16", {63'd0, out_valid16}, {63'd0, v_exp});
    chk("sum4", 64'($signed(sum4)), e.r4.sum);
    chk("sum_sat4", 64'($signed(sum_sat4)), e.r4.sat);
    chk("ovf4", {63'd0, ovf4}, {63'd0, e.r4.ovf});
    chk("sum16", 64'($signed(sum16)), e.r16.sum);
    chk("sum_sat16", 64'($signed(sum_sat16)), e.r16.sat);
    chk("ovf16", {63'd0, ovf16}, {63'd0, e.r16.ovf});
  endtask

  // Drives one cycle of stimulus.
  // Valid operands push an expectation onto the scoreboard. After the edge,
  // the expectation is popped and compared; an idle cycle must show the
  // held result.
  task automatic step(input bit v, input longint x4, input longint y4, input bit s4,
                      input res_t e4, input longint x16, input longint y16, input bit s16);
    sb_t e;
    in_valid = v;
    a4 = x4[3:0];  b4 = y4[3:0];  sub4 = s4;
    a16 = x16[15:0]; b16 = y16[15:0]; sub16 = s16;
    if (v) begin
      e.r4  = e4;
      e.r16 = model(16, x16, y16, s16);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (v) begin
      if (sb.size() == 0) begin
        chk("scoreboard_empty", 64'd1, 64'd0);
        e = held;
      end else begin
        e = sb.pop_front();
      end
      held = e;
    end else begin
      e = held;
    end
    check_outputs(v, e);
  endtask

  task automatic op(input bit v, input longint x4, input longint y4, input bit s);
    step(v, x4, y4, s, model(4, x4, y4, s), x4, y4, s);
  endtask

  initial begin
    sb_t zero;
    zero.r4.sum = 0;  zero.r4.sat = 0;  zero.r4.ovf = 0;
    zero.r16.sum = 0; zero.r16.sat = 0; zero.r16.ovf = 0;
    held = zero;

    tab[0] = mk( 3,  2, 0,   5,  5, 0);
    tab[1] = mk(-4,  1, 0,  -3, -3, 0);
    tab[2] = mk( 7, -2, 0,   5,  5, 0);
    tab[3] = mk(-5, -3, 0,  -8, -8, 0);
    tab[4] = mk( 6,  3, 0,   9,  7, 1);
    tab[5] = mk(-8, -8, 0, -16, -8, 1);
    tab[6] = mk( 7, -8, 1,  15,  7, 1);
    tab[7] = mk(-8,  7, 1, -15, -8, 1);

    rst_n = 1'b0; in_valid = 1'b0;
    a4 = '0; b4 = '0; sub4 = 1'b0; a16 = '0; b16 = '0; sub16 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs(1'b0, zero);
    rst_n = 1'b1;

    // Directed vectors, back-to-back.
    for (int i = 0; i < 8; i++)
      step(1'b1, tab[i].a, tab[i].b, tab[i].sub, tab[i].exp, tab[i].a, tab[i].b, tab[i].sub);

    // New operands without in_valid: outputs hold and out_valid drops.
    op(1'b0, 1, 1, 0);
    op(1'b0, -3, 5, 1);

    // Five back-to-back operations; their order is checked through the values.
    op(1'b1, 1, 2, 0);
    op(1'b1, 2, 3, 1);
    op(1'b1, -1, -1, 0);
    op(1'b1, 5, -6, 1);
    op(1'b1, 0, 7, 1);

    // Asynchronous reset mid-cycle while outputs are nonzero and an op is pending.
    op(1'b1, 6, 6, 0);
    in_valid = 1'b1; a4 = 4'd3; b4 = 4'd3; a16 = 16'd3; b16 = 16'd3;
    #1 rst_n = 1'b0;
    #1;
    check_outputs(1'b0, zero);
    sb.delete();
    held = zero;
    @(posedge clk);
    #1;
    check_outputs(1'b0, zero);
    rst_n = 1'b1;
    op(1'b0, 2, 2, 0);
    op(1'b1, -2, 3, 1);

    // Randomised operands with occasional idle cycles.
    for (int i = 0; i < 10000; i++) begin
      longint x4, y4, x16, y16;
      bit v, s4, s16;
      v   = ($urandom_range(0, 9) != 0);
      x4  = longint'($urandom_range(0, 15)) - 8;
      y4  = longint'($urandom_range(0, 15)) - 8;
      x16 = longint'($urandom_range(0, 65535)) - 32768;
      y16 = longint'($urandom_range(0, 65535)) - 32768;
      s4  = 1'($urandom_range(0, 1));
      s16 = 1'($urandom_range(0, 1));
      step(v, x4, y4, s4, model(4, x4, y4, s4), x16, y16, s16);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
